// File: rtl/stdmacro_skid_buffer.sv
// -----------------------------------------------------------------------------
// stdmacro_skid_buffer
//
// Two-entry valid/ready register slice. It cuts the forward path (valid/data)
// and the backward path (ready) with flops while still sustaining one transfer
// per cycle. The main register is always the head entry and drives m_data_o.
// The skid register holds a second entry only while the downstream stalls.
//
// Parameters:
//   DATA_WIDTH        payload width in bits (>= 1)
//   DATA_RESET_VALUE  value loaded into both storage registers on reset
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   reset_i      synchronous active-high reset
//   flush_i      synchronous discard of all buffered entries
//   s_valid_i    upstream offers s_data_i
//   s_ready_o    stage can accept (flop output)
//   s_data_i     upstream payload
//   m_valid_o    m_data_o is valid (flop output)
//   m_ready_i    downstream accepts m_data_o
//   m_data_o     downstream payload (main register)
//   occupancy_o  number of entries held, 0..2 (the state register)
// -----------------------------------------------------------------------------
module stdmacro_skid_buffer #(
    parameter int                    DATA_WIDTH       = 1,
    parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            occupancy_o
);

    // The encoding equals the number of entries held, so the state register
    // doubles as the occupancy output.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic                    s_ready_q;
    logic                    m_valid_q;
    logic [DATA_WIDTH-1:0]   main_q;
    logic [DATA_WIDTH-1:0]   main_d;
    logic [DATA_WIDTH-1:0]   skid_q;
    logic                    main_en;
    logic                    skid_en;
    logic                    accept;
    logic                    emit;

    assign accept = s_valid_i & s_ready_q;
    assign emit   = m_valid_q & m_ready_i;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = s_data_i;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_en = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && emit) begin
                    // Head leaves and the new entry replaces it: no bubble.
                    main_en = 1'b1;
                end else if (accept) begin
                    skid_en = 1'b1;
                    state_d = ST_FULL;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // s_ready is low here, so only the drain from skid can happen.
                if (emit) begin
                    main_en = 1'b1;
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush drops everything: handshakes in this cycle still complete on
        // the wire but leave no trace, and the data registers keep stale data.
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    // Handshake outputs are re-derived from the next state so that neither
    // s_ready_o nor m_valid_o has a combinational path from any input.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_EMPTY;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            main_q    <= DATA_RESET_VALUE;
            skid_q    <= DATA_RESET_VALUE;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d != ST_FULL);
            m_valid_q <= (state_d != ST_EMPTY);
            if (main_en) begin
                main_q <= main_d;
            end
            if (skid_en) begin
                skid_q <= s_data_i;
            end
        end
    end

    assign s_ready_o   = s_ready_q;
    assign m_valid_o   = m_valid_q;
    assign m_data_o    = main_q;
    assign occupancy_o = state_q;

endmodule

// File: doc/stdmacro_skid_buffer.md
# stdmacro_skid_buffer

Two-entry valid/ready pipeline register slice (skid buffer) for breaking combinational timing paths across pipeline boundaries. It registers both the forward path (valid/data) and the backward path (ready) while sustaining one transfer per cycle. It sits between adjacent pipeline stages and holds its storage in enable-gated data flops. Every handshake boundary in the core that needs a full register cut, in both directions, is built from this stage.

## Interface
- DATA_WIDTH, 1, payload width in bits (≥1)
- DATA_RESET_VALUE, 'b0, DATA_WIDTH-bit value loaded into both storage registers on reset
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  reset; synchronous, active-high
- flush  input  1  synchronous discard of all buffered entries
- s_valid  input  1  upstream offers s_data
- s_ready  output  1  stage can accept; driven directly from a flop
- s_data  input  DATA_WIDTH  upstream payload
- m_valid  output  1  m_data is valid; driven directly from a flop
- m_ready  input  1  downstream accepts m_data
- m_data  output  DATA_WIDTH  downstream payload; driven directly from the main register
- occupancy  output  2  number of entries held (0..2)

## Operation
- Storage:
  - main register: always the head entry, drives m_data.
  - skid register: second entry, used only while downstream stalls.
- Handshakes:
  - accept = s_valid & s_ready.
  - emit = m_valid & m_ready.
  - Standard rule: once m_valid is asserted, m_valid and m_data hold until emit. Upstream must not be required to do the same; it is allowed to, but the buffer does not rely on it.
- State machine. State is encoded in occupancy.
  - EMPTY (0): m_valid=0, s_ready=1. accept → main<=s_data, go to BUSY.
  - BUSY (1): m_valid=1, s_ready=1.
    - accept & emit → main<=s_data, stay BUSY.
    - accept & !emit → skid<=s_data, go to FULL.
    - !accept & emit → go to EMPTY.
    - Otherwise hold.
  - FULL (2): m_valid=1, s_ready=0.
    - emit → main<=skid, go to BUSY.
    - Otherwise hold. accept is impossible because s_ready=0.
- Registered outputs: s_ready, m_valid and occupancy are registered and derived from the next state, with no combinational path from any input.
- flush:
  - Highest priority below reset. Next state is EMPTY, s_ready=1 and m_valid=0 next cycle.
  - Any accept or emit in the flush cycle is discarded: upstream sees the handshake complete, the data is dropped, and no entry is recorded.
  - Data registers are not cleared by flush; they retain stale contents.
- Data register enables:
  - main enabled only on: EMPTY accept, BUSY accept&emit, or FULL emit.
  - skid enabled only on: BUSY accept&!emit.
  - With no enable, both registers hold their value.
- Ordering: strict FIFO, no reordering or duplication; every accepted entry is emitted exactly once unless flushed.

## Timing
- Reset values (cycle after reset sampled high):
  - s_ready=1, m_valid=0, occupancy=0.
  - m_data=DATA_RESET_VALUE, skid=DATA_RESET_VALUE.
- Reset mid-operation: all entries are dropped regardless of s_valid/m_ready in that cycle; reset dominates flush.
- Latency: an entry accepted at edge N appears with m_valid=1 after edge N (visible in cycle N+1). Minimum latency is 1 cycle.
- Throughput: 1 entry/cycle steady state with m_ready held high; s_ready never deasserts in that case.
- Backpressure:
  - m_ready low while BUSY with accept → FULL next cycle, s_ready=0 from that cycle.
  - The first m_ready high in FULL re-raises s_ready the following cycle.
- Simultaneous events:
  - accept+emit in BUSY keeps occupancy 1 with no bubble.
  - flush with accept in EMPTY leaves EMPTY.
- Protocol violations: s_valid asserted while s_ready=0 is legal and ignored; upstream keeps offering.

## Test plan
- Reset, then idle: reset=1 for 2 cycles → s_ready=1, m_valid=0, occupancy=0, m_data=DATA_RESET_VALUE (DATA_WIDTH=8, reset value 8'hA5 → m_data=8'hA5).
- Streaming:
  - Stimulus: s_valid=1 with data 0x01..0x10 on consecutive cycles, m_ready=1 throughout.
  - Required: m_data=0x01..0x10 starting one cycle after first accept, no gaps, s_ready constantly 1, occupancy stays 1.
- Stall fill:
  - Stimulus: m_ready=0, push 0x11 then 0x22.
  - Required: occupancy 1 then 2, s_ready=0 after second accept, and 0x33 offered is not accepted. Then m_ready=1 → emits 0x11, 0x22, then 0x33 in order.
- Alternating backpressure:
  - Stimulus: m_ready toggling 1/0 each cycle with continuous s_valid of incrementing data for 64 cycles.
  - Required: scoreboard confirms in-order, lossless, no duplicates, and occupancy never exceeds 2.
- Flush in FULL:
  - Stimulus: state FULL holding 0x44, 0x55; assert flush with s_valid=1 data 0x66.
  - Required: next cycle m_valid=0, occupancy=0, s_ready=1. 0x44, 0x55 and 0x66 are never emitted, and subsequent push 0x77 emits as the first entry.
- Reset mid-transfer:
  - Stimulus: reset asserted in a cycle with accept and emit both active in BUSY.
  - Required: next cycle occupancy=0, m_valid=0, m_data=DATA_RESET_VALUE.
